subleq_exec_ctrl: RTL and testbench

- Sequential execute controller for the URISC core; the stage directly downstream of the global word/field definitions.
- Fetches one 64-bit SUBLEQ instruction word at PC and slices operand fields A[19:0], B[39:20] and C[59:40].
- Reads mem[A] and mem[B], writes mem[B]-mem[A] back to B, then branches to C if the result is <=0, else advances PC.
- Drives a single shared memory port through a req/ack handshake.

---
 rtl/subleq_exec_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_subleq_exec_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_exec_ctrl.sv
// SUBLEQ execute controller: fetch, two operand reads, write-back and branch over one req/ack port.
// Optional retired-instruction counter on retired_cnt_o when SUBLEQ_PERF_CNT_EN is defined.
module subleq_exec_ctrl #(
  parameter int                WORD_W    = 64,
  parameter int                ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] HALT_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_pc_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
`ifdef SUBLEQ_PERF_CNT_EN
  output logic [63:0]       retired_cnt_o,
`endif
  output logic              halted_o
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // FETCH  | reading instruction word at pc
  // RD_A   | reading mem[A]
  // RD_B   | reading mem[B]
  // WRITE  | writing mem[B]-mem[A] to B
  // NEXT   | branch decision, one cycle
  // HALTED | taken branch to HALT_ADDR; waits for start
  typedef enum logic [2:0] {
    IDLE, FETCH, RD_A, RD_B, WRITE, NEXT, HALTED
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [WORD_W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic                req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [63:0]         cnt_q, cnt_d;
  logic [WORD_W-1:0]   res;
  logic                leq;
  logic                acked;

  assign res   = opb_q - opa_q;
  assign leq   = res[WORD_W-1] | (res == '0);
  // An ack only completes a request that is actually outstanding.
  assign acked = req_q & mem_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, HALTED: begin
        if (start_i) begin
          pc_d    = start_pc_i;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (acked) begin
          req_d   = 1'b0;
          a_d     = mem_rdata_i[ADDR_W-1:0];
          b_d     = mem_rdata_i[2*ADDR_W-1:ADDR_W];
          c_d     = mem_rdata_i[3*ADDR_W-1:2*ADDR_W];
          state_d = RD_A;
        end
      end
      RD_A: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = a_q;
        end else if (acked) begin
          req_d   = 1'b0;
          opa_d   = mem_rdata_i;
          state_d = RD_B;
        end
      end
      RD_B: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = b_q;
        end else if (acked) begin
          req_d   = 1'b0;
          opb_d   = mem_rdata_i;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!req_q) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = b_q;
          wdata_d = res;
        end else if (acked) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = NEXT;
        end
      end
      NEXT: begin
        cnt_d = cnt_q + 64'd1;
        if (leq && (c_q == HALT_ADDR)) begin
          state_d = HALTED;
        end else if (leq) begin
          pc_d    = c_q;
          state_d = FETCH;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign pc_o        = pc_q;
  assign busy_o      = (state_q != IDLE) && (state_q != HALTED);
  assign halted_o    = (state_q == HALTED);

`ifdef SUBLEQ_PERF_CNT_EN
  assign retired_cnt_o = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_subleq_exec_ctrl.sv
// Directed bench for subleq_exec_ctrl with a behavioural memory that acks after a chosen delay.
module tb_subleq_exec_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [19:0] start_pc_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [19:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [63:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [19:0] pc_o;
  logic        busy_o, halted_o;
`ifdef SUBLEQ_PERF_CNT_EN
  logic [63:0] retired_cnt_o;
`endif

  subleq_exec_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .start_pc_i(start_pc_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .pc_o(pc_o), .busy_o(busy_o),
`ifdef SUBLEQ_PERF_CNT_EN
    .retired_cnt_o(retired_cnt_o),
`endif
    .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [logic [19:0]];
  int          nwrites = 0;
  logic [19:0] last_waddr = '0;
  logic [63:0] last_wdata = '0;
  bit          resp_en = 1'b1;
  bit          rand_mode = 1'b0;
  int          fixed_delay = 0;
  int          cur_delay = 0;
  int          wcnt = 0;
  logic [19:0] cap_addr;
  logic        cap_we;
  logic [63:0] cap_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Top nibble is junk on purpose: the fetch must ignore it.
  function automatic logic [63:0] ins(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c);
    return {4'hA, c, b, a};
  endfunction

  function automatic int pick_delay();
    int sel;
    if (!rand_mode) return fixed_delay;
    sel = $urandom_range(0, 2);
    return (sel == 0) ? 0 : (sel == 1) ? 1 : 5;
  endfunction

  // Memory responder: observes registered request outputs 1 time unit after each edge.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (rst_i) begin
        mem_ack_i = 1'b0;
        wcnt = 0;
        cur_delay = pick_delay();
      end else if (!resp_en) begin
        wcnt = 0;
      end else if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        chk("req_drop_after_ack", {63'd0, mem_req_o}, 64'd0);
      end else if (mem_req_o) begin
        if (wcnt == 0) begin
          cap_addr = mem_addr_o;
          cap_we = mem_we_o;
          cap_wdata = mem_wdata_o;
        end else begin
          chk("stable_addr", {44'd0, mem_addr_o}, {44'd0, cap_addr});
          chk("stable_we", {63'd0, mem_we_o}, {63'd0, cap_we});
          if (cap_we) chk("stable_wdata", mem_wdata_o, cap_wdata);
        end
        if (wcnt >= cur_delay) begin
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            last_waddr = mem_addr_o;
            last_wdata = mem_wdata_o;
            nwrites++;
          end else begin
            mem_rdata_i = rd(mem_addr_o);
          end
          mem_ack_i = 1'b1;
          wcnt = 0;
          cur_delay = pick_delay();
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
  endtask

  task automatic start_at(input logic [19:0] p);
    @(negedge clk_i); start_i = 1'b1; start_pc_i = p;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  task automatic run_instr(input string tag, input logic [19:0] waddr, input logic [63:0] wdata,
                           input logic [19:0] exp_pc, input logic exp_halt);
    int  n0;
    bit  got;
    n0 = nwrites;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk_i); #2;
      if (nwrites != n0) got = 1'b1;
    end
    chk({tag, "_write_seen"}, {63'd0, got}, 64'd1);
    chk({tag, "_waddr"}, {44'd0, last_waddr}, {44'd0, waddr});
    chk({tag, "_wdata"}, last_wdata, wdata);
    @(posedge clk_i); @(posedge clk_i); #2;
    chk({tag, "_pc"}, {44'd0, pc_o}, {44'd0, exp_pc});
    chk({tag, "_halted"}, {63'd0, halted_o}, {63'd0, exp_halt});
    chk({tag, "_busy"}, {63'd0, busy_o}, {63'd0, ~exp_halt});
  endtask

  initial begin
    int  n0;
    bit  got;

    // reset values
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_pc", {44'd0, pc_o}, 64'd0);
    chk("rst_req", {63'd0, mem_req_o}, 64'd0);
    chk("rst_we", {63'd0, mem_we_o}, 64'd0);
    chk("rst_addr", {44'd0, mem_addr_o}, 64'd0);
    chk("rst_wdata", mem_wdata_o, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_halted", {63'd0, halted_o}, 64'd0);
`ifdef SUBLEQ_PERF_CNT_EN
    chk("rst_cnt", retired_cnt_o, 64'd0);
`endif

    // basic subtract, not taken
    mem.delete();
    mem[20'h0] = ins(20'h10, 20'h11, 20'h9);
    mem[20'h10] = 64'd3;
    mem[20'h11] = 64'd10;
    start_at(20'h0);
    run_instr("basic", 20'h11, 64'd7, 20'h1, 1'b0);

    // taken on zero; a start while busy must be ignored
    do_reset();
    mem.delete();
    mem[20'h0] = ins(20'h10, 20'h11, 20'h9);
    mem[20'h10] = 64'd10;
    mem[20'h11] = 64'd10;
    start_at(20'h0);
    repeat (2) @(negedge clk_i);
    start_at(20'h77);
    run_instr("zero", 20'h11, 64'd0, 20'h9, 1'b0);

    // taken on negative, with every ack delayed 5 cycles
    do_reset();
    fixed_delay = 5;
    mem.delete();
    mem[20'h0] = ins(20'h10, 20'h11, 20'h9);
    mem[20'h10] = 64'd11;
    mem[20'h11] = 64'd10;
    start_at(20'h0);
    run_instr("neg", 20'h11, 64'hFFFF_FFFF_FFFF_FFFF, 20'h9, 1'b0);
    fixed_delay = 0;

    // halt, then restart at 5
    do_reset();
    mem.delete();
    mem[20'h0] = ins(20'h20, 20'h20, 20'hFFFFF);
    mem[20'h20] = 64'h1234;
    mem[20'h5] = ins(20'h30, 20'h31, 20'h9);
    mem[20'h30] = 64'd1;
    mem[20'h31] = 64'd4;
    start_at(20'h0);
    run_instr("halt", 20'h20, 64'd0, 20'h0, 1'b1);
`ifdef SUBLEQ_PERF_CNT_EN
    chk("halt_cnt", retired_cnt_o, 64'd1);
`endif
    start_at(20'h5);
    chk("restart_pc", {44'd0, pc_o}, 64'h5);
    chk("restart_halted", {63'd0, halted_o}, 64'd0);
`ifdef SUBLEQ_PERF_CNT_EN
    chk("restart_cnt", retired_cnt_o, 64'd0);
`endif
    @(negedge clk_i);
    chk("restart_fetch_addr", {44'd0, mem_addr_o}, 64'h5);
    run_instr("restart", 20'h31, 64'd3, 20'h6, 1'b0);

    // random stalls of 0/1/5 cycles
    do_reset();
    rand_mode = 1'b1;
    mem.delete();
    mem[20'h0] = ins(20'h10, 20'h11, 20'h9);
    mem[20'h10] = 64'd3;
    mem[20'h11] = 64'd10;
    start_at(20'h0);
    run_instr("stall", 20'h11, 64'd7, 20'h1, 1'b0);
    rand_mode = 1'b0;

    // pc wrap: 0xFFFFE -> 0xFFFFF -> 0
    do_reset();
    mem.delete();
    mem[20'hFFFFE] = ins(20'h10, 20'h11, 20'h9);
    mem[20'h10] = 64'd3;
    mem[20'h11] = 64'd10;
    mem[20'hFFFFF] = ins(20'h40, 20'h41, 20'h9);
    mem[20'h40] = 64'd1;
    mem[20'h41] = 64'd2;
    start_at(20'hFFFFE);
    run_instr("wrap1", 20'h11, 64'd7, 20'hFFFFF, 1'b0);
    run_instr("wrap2", 20'h41, 64'd1, 20'h0, 1'b0);

    // signed overflow: 0x8000.. - 1 is positive, not taken
    do_reset();
    mem.delete();
    mem[20'h0] = ins(20'h10, 20'h11, 20'h9);
    mem[20'h10] = 64'd1;
    mem[20'h11] = 64'h8000_0000_0000_0000;
    start_at(20'h0);
    run_instr("ovf", 20'h11, 64'h7FFF_FFFF_FFFF_FFFF, 20'h1, 1'b0);

    // reset while a write is outstanding, then a stray ack
    do_reset();
    fixed_delay = 5;
    mem.delete();
    mem[20'h0] = ins(20'h10, 20'h11, 20'h9);
    mem[20'h10] = 64'd3;
    mem[20'h11] = 64'd10;
    start_at(20'h0);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk_i); #2;
      if (mem_req_o && mem_we_o) got = 1'b1;
    end
    chk("midwr_seen", {63'd0, got}, 64'd1);
    n0 = nwrites;
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #2;
    chk("midwr_req", {63'd0, mem_req_o}, 64'd0);
    chk("midwr_we", {63'd0, mem_we_o}, 64'd0);
    chk("midwr_busy", {63'd0, busy_o}, 64'd0);
    chk("midwr_pc", {44'd0, pc_o}, 64'd0);
    @(negedge clk_i); rst_i = 1'b0; resp_en = 1'b0; mem_ack_i = 1'b1;
    @(negedge clk_i); mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("late_ack_req", {63'd0, mem_req_o}, 64'd0);
    chk("late_ack_busy", {63'd0, busy_o}, 64'd0);
    chk("late_ack_pc", {44'd0, pc_o}, 64'd0);
    chk("late_ack_nowrite", nwrites - n0, 64'd0);
`ifdef SUBLEQ_PERF_CNT_EN
    chk("late_ack_cnt", retired_cnt_o, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
